// File: rtl/stage_tracker.sv
// stage_tracker: timestamps one trace element's residency in a pipeline stage
// and queues completed elements in a DEPTH-entry valid/ready output FIFO.
// Optional stall timeout: define STAGE_TRACKER_TIMEOUT_EN.

module stage_tracker #(
    parameter int ELEM_WIDTH     = 128,
    parameter int TIME_WIDTH     = 32,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [TIME_WIDTH-1:0]   counter,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ELEM_WIDTH-1:0]   in_elem,
    input  logic                    stage_busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ELEM_WIDTH-1:0]   out_elem,
    output logic [TIME_WIDTH-1:0]   out_time_start,
    output logic [TIME_WIDTH-1:0]   out_time_end,
    output logic [TIME_WIDTH-1:0]   out_duration,
    output logic                    out_timeout,
    output logic [$clog2(DEPTH):0]  occupancy
);

    localparam int AW  = $clog2(DEPTH);
    localparam int OW  = AW + 1;
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  ready_q, ready_d;
    logic [ELEM_WIDTH-1:0] elem_q, elem_d;
    logic [TIME_WIDTH-1:0] start_q, start_d;
    logic [TIME_WIDTH-1:0] end_q, end_d;
    logic                  to_q, to_d;
    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         rptr_q, rptr_d;
    logic [OW-1:0]         occ_q, occ_d;

    logic                  pop;
    logic                  room;
    logic                  close;
    logic                  push;
    logic                  timeout_hit;
    logic [TIME_WIDTH-1:0] push_end;
    logic                  push_to;

    logic [ELEM_WIDTH-1:0] elem_mem  [DEPTH];
    logic [TIME_WIDTH-1:0] start_mem [DEPTH];
    logic [TIME_WIDTH-1:0] end_mem   [DEPTH];
    logic                  to_mem    [DEPTH];

`ifdef STAGE_TRACKER_TIMEOUT_EN
    logic [TCW-1:0] tcnt_q, tcnt_d;

    // Stall counter: zero outside ACTIVE, counts cycles spent in ACTIVE
    always_comb begin
        tcnt_d = '0;
        if (state_q == ACTIVE) tcnt_d = tcnt_q + TCW'(1);
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tcnt_q <= '0;
        else      tcnt_q <= tcnt_d;
    end

    assign timeout_hit = (state_q == ACTIVE) && stage_busy &&
                         (tcnt_q == TCW'(TIMEOUT_CYCLES - 1));
`else
    logic [TCW-1:0] unused_tcnt;
    assign unused_tcnt = '0;
    assign timeout_hit = 1'b0;
`endif

    // Capture FSM next state and push decision
    always_comb begin
        state_d  = state_q;
        elem_d   = elem_q;
        start_d  = start_q;
        end_d    = end_q;
        to_d     = to_q;
        pop      = (occ_q != '0) && out_ready;
        room     = (occ_q < OW'(DEPTH)) || pop;
        close    = (state_q == ACTIVE) && (!stage_busy || timeout_hit);
        push     = 1'b0;
        push_end = counter;
        push_to  = timeout_hit;
        unique case (state_q)
            IDLE: begin
                if (ready_q && in_valid) begin
                    elem_d  = in_elem;
                    start_d = counter;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (close) begin
                    end_d = counter;
                    to_d  = timeout_hit;
                    if (room) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                push_end = end_q;
                push_to  = to_q;
                if (room) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    // FIFO pointer and occupancy next state
    always_comb begin
        wptr_d = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
        occ_d  = occ_q;
        if (push && !pop) occ_d = occ_q + OW'(1);
        if (pop && !push) occ_d = occ_q - OW'(1);
    end

    // Control and capture registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            elem_q  <= '0;
            start_q <= '0;
            end_q   <= '0;
            to_q    <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            elem_q  <= elem_d;
            start_q <= start_d;
            end_q   <= end_d;
            to_q    <= to_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            occ_q   <= occ_d;
        end
    end

    // FIFO storage; contents are invalidated by the pointer reset
    always_ff @(posedge clk) begin
        if (push) begin
            elem_mem[wptr_q]  <= elem_q;
            start_mem[wptr_q] <= start_q;
            end_mem[wptr_q]   <= push_end;
            to_mem[wptr_q]    <= push_to;
        end
    end

    assign in_ready       = ready_q;
    assign out_valid      = (occ_q != '0);
    assign out_elem       = elem_mem[rptr_q];
    assign out_time_start = start_mem[rptr_q];
    assign out_time_end   = end_mem[rptr_q];
    assign out_duration   = end_mem[rptr_q] - start_mem[rptr_q];
    assign out_timeout    = to_mem[rptr_q];
    assign occupancy      = occ_q;

endmodule

// File: tb/tb_stage_tracker.sv
// tb_stage_tracker: directed and randomized checks of stage_tracker
// against a transaction-level model of element residency and the FIFO.

module tb_stage_tracker;

    localparam int EW = 16;
    localparam int TW = 8;
    localparam int D  = 4;
    localparam int TC = 8;
`ifdef STAGE_TRACKER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [TW-1:0]        counter = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [EW-1:0]        in_elem = '0;
    logic                 stage_busy = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [EW-1:0]        out_elem;
    logic [TW-1:0]        out_time_start;
    logic [TW-1:0]        out_time_end;
    logic [TW-1:0]        out_duration;
    logic                 out_timeout;
    logic [$clog2(D):0]   occupancy;

    stage_tracker #(
        .ELEM_WIDTH(EW), .TIME_WIDTH(TW), .DEPTH(D), .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk(clk), .rst(rst), .counter(counter),
        .in_valid(in_valid), .in_ready(in_ready), .in_elem(in_elem),
        .stage_busy(stage_busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_elem(out_elem),
        .out_time_start(out_time_start), .out_time_end(out_time_end),
        .out_duration(out_duration), .out_timeout(out_timeout),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [EW-1:0] elem;
        logic [TW-1:0] ts;
        logic [TW-1:0] te;
        logic          to;
    } ent_t;

    ent_t fifo[$];
    ent_t cur;
    bit   have, closed, rdy;
    int   elapsed;
    int   checks = 0;
    int   errors = 0;
    int   accepts = 0;
    int   pops = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [TW-1:0] dur;
        chk("in_ready", {31'd0, in_ready}, {31'd0, rdy && !have});
        chk("out_valid", {31'd0, out_valid}, {31'd0, fifo.size() > 0});
        chk("occupancy", 32'(occupancy), 32'(fifo.size()));
        if (fifo.size() > 0) begin
            dur = fifo[0].te - fifo[0].ts;
            chk("head_elem", 32'(out_elem), 32'(fifo[0].elem));
            chk("head_start", 32'(out_time_start), 32'(fifo[0].ts));
            chk("head_end", 32'(out_time_end), 32'(fifo[0].te));
            chk("head_dur", 32'(out_duration), 32'(dur));
            chk("head_to", {31'd0, out_timeout}, {31'd0, fifo[0].to});
        end
    endtask

    // One clock cycle: check, drive, advance the model, move the counter.
    task automatic step(input bit iv, input logic [EW-1:0] e,
                        input bit b, input bit ordy);
        bit ir, pop_m, room, push_m;
        check_outputs();
        in_valid   = iv;
        in_elem    = e;
        stage_busy = b;
        out_ready  = ordy;
        ir     = rdy && !have;
        pop_m  = (fifo.size() > 0) && ordy;
        room   = (fifo.size() < D) || pop_m;
        push_m = 1'b0;
        if (have && !closed) begin
            elapsed++;
            if (!b || (TO_EN && elapsed == TC)) begin
                cur.te = counter;
                cur.to = b;
                if (room) push_m = 1'b1;
                else      closed = 1'b1;
            end
        end else if (have && closed) begin
            if (room) push_m = 1'b1;
        end else if (ir && iv) begin
            have    = 1'b1;
            closed  = 1'b0;
            elapsed = 0;
            cur.elem = e;
            cur.ts   = counter;
            cur.te   = '0;
            cur.to   = 1'b0;
            accepts++;
        end
        if (pop_m) begin
            void'(fifo.pop_front());
            pops++;
        end
        if (push_m) begin
            fifo.push_back(cur);
            have = 1'b0;
        end
        rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        counter = counter + 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        fifo.delete();
        have   = 1'b0;
        closed = 1'b0;
        rdy    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        stage_busy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [TW-1:0] latched;
        int acc0, pop0, thr;
        @(negedge clk);
        do_reset();
        step(0, '0, 0, 0);

        // Basic single element
        counter = 8'd100;
        step(1, 16'h00A1, 0, 0);
        repeat (3) step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        chk("basic_start", 32'(out_time_start), 32'd100);
        chk("basic_end", 32'(out_time_end), 32'd104);
        chk("basic_dur", 32'(out_duration), 32'd4);
        chk("basic_occ1", 32'(occupancy), 32'd1);
        step(0, '0, 0, 1);
        chk("basic_occ0", 32'(occupancy), 32'd0);

        // Full FIFO, fifth element parks in HOLD
        for (int i = 0; i < D; i++) begin
            step(1, EW'(16'h0B00 + i), 0, 0);
            step(0, '0, 0, 0);
        end
        step(1, 16'h0B05, 0, 0);
        latched = counter;
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);
        chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        chk("hold_occ", 32'(occupancy), 32'd4);
        step(0, '0, 0, 1);
        chk("swap_occ", 32'(occupancy), 32'd4);
        chk("swap_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) step(0, '0, 0, 1);
        chk("hold_elem", 32'(out_elem), 32'h0B05);
        chk("hold_end", 32'(out_time_end), 32'(latched));
        step(0, '0, 0, 1);

        // Counter wrap
        counter = 8'd250;
        step(1, 16'h00C1, 0, 1);
        repeat (10) step(0, '0, 1, 1);
        step(0, '0, 0, 1);
        chk("wrap_start", 32'(out_time_start), 32'd250);
        chk("wrap_end", 32'(out_time_end), 32'd5);
        chk("wrap_dur", 32'(out_duration), 32'd11);
        step(0, '0, 0, 1);

        // Reset with two queued entries and one in flight
        repeat (2) begin
            step(1, 16'h0DDD, 0, 0);
            step(0, '0, 0, 0);
        end
        step(1, 16'h0DEE, 0, 0);
        step(0, '0, 1, 0);
        do_reset();
        repeat (4) step(0, '0, 0, 1);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

        // Back-to-back streaming
        acc0 = accepts;
        pop0 = pops;
        for (int i = 0; i < 40; i++) step(1, EW'(16'h1000 + i), 0, 1);
        chk("stream_accepts", 32'(accepts - acc0), 32'd20);
        chk("stream_pops", 32'(pops - pop0), 32'd19);
        in_valid = 1'b0;
        repeat (3) step(0, '0, 0, 1);

`ifdef STAGE_TRACKER_TIMEOUT_EN
        step(1, 16'h00E1, 0, 1);
        repeat (TC) step(0, '0, 1, 1);
        chk("to_valid", {31'd0, out_valid}, 32'd1);
        chk("to_flag", {31'd0, out_timeout}, 32'd1);
        chk("to_dur", 32'(out_duration), 32'(TC));
        step(0, '0, 0, 1);
`endif

        // Randomized traffic with varying downstream pressure
        for (int p = 0; p < 4; p++) begin
            thr = (p % 2 == 0) ? 3 : 9;
            for (int i = 0; i < 100; i++)
                step($urandom_range(0, 3) != 0, EW'($urandom()),
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 9) < thr);
        end
        repeat (20) step(0, '0, 0, 1);
        chk("drain_empty", {31'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
